// File: rtl/rp_pkg.sv
// Shared types and sizing for the repeated-pattern mask decoder.
package rp_pkg;

   typedef enum logic [1:0] {
      RP_IDLE,
      RP_CAPTURE,
      RP_CHECK,
      RP_DONE
   } rp_state_e;

   localparam int unsigned RP_PAT_MAX = 32;
   localparam int unsigned RP_CNT_W   = 22;

endpackage

// File: rtl/rp_sat_counter.sv
// Up-counter with synchronous clear that holds once it reaches sat_i.
module rp_sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic             inc_i,
   input  logic [WIDTH-1:0] sat_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i && (count_q != sat_i)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else if (en_i) begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/rp_pattern_decoder.sv
// Receive side of the repeated-pattern mask stream: captures the first w bits
// as the pattern, then checks every later bit against it until the frame ends.
module rp_pattern_decoder
   import rp_pkg::*;
#(
   parameter int unsigned image_sensor_w = 300,
   parameter int unsigned image_sensor_h = 300,
   parameter int unsigned CNT_W          = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clk_en,
   input  logic [4:0]            pattern_w,
   input  logic                  start,
   input  logic                  rp_mask_bit,
   input  logic                  rp_valid,
   output logic [0:RP_PAT_MAX-1] pattern_out,
   output logic                  pattern_valid,
   output logic                  busy,
   output logic                  mismatch,
   output logic [CNT_W-1:0]      mismatch_count,
   output logic [RP_CNT_W-1:0]   bit_count,
   output logic                  done,
   output logic                  cfg_err
);

   // Bits beyond one row cannot belong to a frame; reaching this ends it.
   localparam logic [RP_CNT_W-1:0] BIT_SAT = RP_CNT_W'(image_sensor_w + 1);

   // Row count is reserved for a future frame-size check.
   if (image_sensor_h == 0) begin : g_h_reserved
   end

   rp_state_e             state_q, state_d;
   logic [4:0]            w_q, w_d;
   logic [4:0]            idx_q, idx_d;
   logic [0:RP_PAT_MAX-1] pattern_q, pattern_d;
   logic                  pvalid_q, pvalid_d;
   logic                  mismatch_q, mismatch_d;
   logic                  done_q, cfg_err_q, valid_prev_q;

   logic                  restart, frame_end, take_bit, cfg_bad;
   logic                  last_idx, bit_miss, miss_inc;
   logic [4:0]            pos;
   logic [RP_CNT_W-1:0]   bit_count_w;
   logic [CNT_W-1:0]      miss_count_w;

   assign last_idx = (idx_q == (w_q - 5'd1));
   assign pos      = w_q - 5'd1 - idx_q;
   assign bit_miss = rp_mask_bit ^ pattern_q[pos];
   assign miss_inc = take_bit && (state_q == RP_CHECK) && bit_miss;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RP_IDLE;
      end else if (clk_en) begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      restart   = 1'b0;
      frame_end = 1'b0;
      take_bit  = 1'b0;
      cfg_bad   = start && (pattern_w == '0);
      case (state_q)
         RP_IDLE, RP_DONE: begin
            if (start && (pattern_w != '0)) begin
               restart = 1'b1;
               state_d = RP_CAPTURE;
            end
         end
         RP_CAPTURE, RP_CHECK: begin
            if (start && (pattern_w != '0)) begin
               restart = 1'b1;
               state_d = RP_CAPTURE;
            end else if ((bit_count_w == BIT_SAT) || (valid_prev_q && !rp_valid)) begin
               frame_end = 1'b1;
               state_d   = RP_DONE;
            end else if (rp_valid) begin
               take_bit = 1'b1;
               if ((state_q == RP_CAPTURE) && last_idx) begin
                  state_d = RP_CHECK;
               end
            end
         end
         default: state_d = RP_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == RP_CAPTURE) || (state_q == RP_CHECK);
   end

   always_comb begin
      pattern_d  = pattern_q;
      pvalid_d   = pvalid_q;
      mismatch_d = mismatch_q;
      idx_d      = idx_q;
      w_d        = w_q;
      if (restart) begin
         pattern_d  = '0;
         pvalid_d   = 1'b0;
         mismatch_d = 1'b0;
         idx_d      = '0;
         w_d        = pattern_w;
      end else if (take_bit) begin
         idx_d = last_idx ? 5'd0 : idx_q + 5'd1;
         if (state_q == RP_CAPTURE) begin
            pattern_d[pos] = rp_mask_bit;
            if (last_idx) begin
               pvalid_d = 1'b1;
            end
         end else if (bit_miss) begin
            mismatch_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_q          <= '0;
         idx_q        <= '0;
         pattern_q    <= '0;
         pvalid_q     <= 1'b0;
         mismatch_q   <= 1'b0;
         done_q       <= 1'b0;
         cfg_err_q    <= 1'b0;
         valid_prev_q <= 1'b0;
      end else if (clk_en) begin
         w_q          <= w_d;
         idx_q        <= idx_d;
         pattern_q    <= pattern_d;
         pvalid_q     <= pvalid_d;
         mismatch_q   <= mismatch_d;
         done_q       <= frame_end;
         cfg_err_q    <= cfg_bad;
         valid_prev_q <= rp_valid;
      end
   end

   rp_sat_counter #(.WIDTH(RP_CNT_W)) u_bit_cnt (
      .clk_i   (clk),
      .rst_i   (rst),
      .en_i    (clk_en),
      .clr_i   (restart),
      .inc_i   (take_bit),
      .sat_i   (BIT_SAT),
      .count_o (bit_count_w)
   );

   rp_sat_counter #(.WIDTH(CNT_W)) u_miss_cnt (
      .clk_i   (clk),
      .rst_i   (rst),
      .en_i    (clk_en),
      .clr_i   (restart),
      .inc_i   (miss_inc),
      .sat_i   ('1),
      .count_o (miss_count_w)
   );

   assign pattern_out    = pattern_q;
   assign pattern_valid  = pvalid_q;
   assign mismatch       = mismatch_q;
   assign mismatch_count = miss_count_w;
   assign bit_count      = bit_count_w;
   assign done           = done_q;
   assign cfg_err        = cfg_err_q;

endmodule

// File: tb/tb_rp_pattern_decoder.sv
// Self-checking bench: a frame-level model (list of accepted bits) predicts every output each cycle.
module tb_rp_pattern_decoder;

   logic        clk = 1'b0;
   logic        rst, clk_en, start, rp_mask_bit, rp_valid;
   logic [4:0]  pattern_w;
   logic [0:31] pattern_out;
   logic        pattern_valid, busy, mismatch, done, cfg_err;
   logic [15:0] mismatch_count;
   logic [21:0] bit_count;

   always #5 clk = ~clk;

   rp_pattern_decoder #(
      .image_sensor_w (300),
      .image_sensor_h (300),
      .CNT_W          (16)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .clk_en         (clk_en),
      .pattern_w      (pattern_w),
      .start          (start),
      .rp_mask_bit    (rp_mask_bit),
      .rp_valid       (rp_valid),
      .pattern_out    (pattern_out),
      .pattern_valid  (pattern_valid),
      .busy           (busy),
      .mismatch       (mismatch),
      .mismatch_count (mismatch_count),
      .bit_count      (bit_count),
      .done           (done),
      .cfg_err        (cfg_err)
   );

   int unsigned tests = 0;
   int unsigned fails = 0;
   int unsigned done_seen = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Frame model: the frame is just the list of bits the decoder accepted.
   bit m_bits[$];
   int m_w;
   bit m_active, m_prev_v, m_done, m_cfg;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_bits.delete();
         m_w      = 0;
         m_active = 0;
         m_prev_v = 0;
         m_done   = 0;
         m_cfg    = 0;
      end else if (clk_en) begin
         m_done = 0;
         m_cfg  = (start && pattern_w == 0);
         if (start && pattern_w != 0) begin
            m_bits.delete();
            m_w      = int'(pattern_w);
            m_active = 1;
         end else if (m_active) begin
            if (m_bits.size() == 301 || (m_prev_v && !rp_valid)) begin
               m_active = 0;
               m_done   = 1;
            end else if (rp_valid) begin
               m_bits.push_back(rp_mask_bit);
            end
         end
         m_prev_v = rp_valid;
      end
   end

   always @(negedge clk) begin : cmp
      logic [0:31] ep;
      int n, mc;
      n  = m_bits.size();
      ep = '0;
      mc = 0;
      for (int i = 0; i < m_w; i++)
         if (m_w - 1 - i < n) ep[i] = m_bits[m_w - 1 - i];
      for (int k = m_w; k < n; k++)
         if (m_bits[k] != m_bits[k % m_w]) mc++;
      if (mc > 65535) mc = 65535;
      chk("pattern_out",    64'(pattern_out),    64'(ep));
      chk("pattern_valid",  64'(pattern_valid),  64'(m_w != 0 && n >= m_w));
      chk("busy",           64'(busy),           64'(m_active));
      chk("mismatch",       64'(mismatch),       64'(mc != 0));
      chk("mismatch_count", 64'(mismatch_count), 64'(mc));
      chk("bit_count",      64'(bit_count),      64'(n));
      chk("done",           64'(done),           64'(m_done));
      chk("cfg_err",        64'(cfg_err),        64'(m_cfg));
      if (done) done_seen++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic begin_frame(input int w);
      pattern_w = 5'(w);
      start     = 1'b1;
      rp_valid  = 1'b0;
      tick();
      start = 1'b0;
   endtask

   // Streams nbits of pat (MSB of the w-bit pattern first); flip = index to invert.
   task automatic send_bits(input int w, input logic [31:0] pat, input int nbits,
                            input int flip, input int gap_at, input bit rnd, input bit finish);
      int idx;
      for (int k = 0; k < nbits; k++) begin
         idx         = w - 1 - (k % w);
         rp_mask_bit = pat[idx] ^ (k == flip);
         rp_valid    = 1'b1;
         if (rnd && $urandom_range(0, 15) == 0) rp_mask_bit = ~rp_mask_bit;
         if (k == gap_at || (rnd && $urandom_range(0, 7) == 0)) begin
            clk_en = 1'b0;
            repeat ((k == gap_at) ? 3 : $urandom_range(1, 3)) tick();
            clk_en = 1'b1;
         end
         if (rnd && $urandom_range(0, 199) == 0) begin
            start     = 1'b1;
            pattern_w = 5'($urandom_range(1, 31));
         end
         tick();
         start = 1'b0;
      end
      if (finish) begin
         rp_valid = 1'b0;
         tick();
         tick();
      end
   endtask

   task automatic check_frame1(input string tag);
      chk({tag, "_pattern"},   64'(pattern_out),   64'h6800_0000);
      chk({tag, "_pvalid"},    64'(pattern_valid), 64'd1);
      chk({tag, "_mismatch"},  64'(mismatch),      64'd0);
      chk({tag, "_bit_count"}, 64'(bit_count),     64'd301);
      chk({tag, "_done_once"}, 64'(done_seen),     64'd1);
      chk({tag, "_busy"},      64'(busy),          64'd0);
   endtask

   initial begin
      rst = 1'b1; clk_en = 1'b1; start = 1'b0; rp_valid = 1'b0;
      rp_mask_bit = 1'b0; pattern_w = 5'd0;
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("reset_pattern",   64'(pattern_out),    64'd0);
      chk("reset_bit_count", 64'(bit_count),      64'd0);
      chk("reset_flags",     64'({pattern_valid, busy, mismatch, done, cfg_err}), 64'd0);
      chk("reset_mcount",    64'(mismatch_count), 64'd0);

      done_seen = 0;
      begin_frame(5);
      send_bits(5, 32'h16, 301, -1, -1, 1'b0, 1'b1);
      check_frame1("clean");

      done_seen = 0;
      begin_frame(5);
      send_bits(5, 32'h16, 301, 17, -1, 1'b0, 1'b1);
      chk("flip_mismatch", 64'(mismatch),       64'd1);
      chk("flip_mcount",   64'(mismatch_count), 64'd1);
      chk("flip_pattern",  64'(pattern_out),    64'h6800_0000);

      done_seen = 0;
      begin_frame(8);
      send_bits(8, 32'hA5, 5, -1, -1, 1'b0, 1'b1);
      chk("short_done",      64'(done_seen),     64'd1);
      chk("short_pvalid",    64'(pattern_valid), 64'd0);
      chk("short_bit_count", 64'(bit_count),     64'd5);
      chk("short_busy",      64'(busy),          64'd0);

      pattern_w = 5'd0;
      start     = 1'b1;
      tick();
      start = 1'b0;
      chk("cfg_err_pulse", 64'(cfg_err),   64'd1);
      chk("cfg_busy",      64'(busy),      64'd0);
      chk("cfg_bit_count", 64'(bit_count), 64'd5);
      tick();
      chk("cfg_err_clear", 64'(cfg_err),   64'd0);

      done_seen = 0;
      begin_frame(5);
      send_bits(5, 32'h16, 301, -1, 40, 1'b0, 1'b1);
      check_frame1("gap");

      begin_frame(5);
      send_bits(5, 32'h16, 100, -1, -1, 1'b0, 1'b0);
      rp_valid = 1'b0;
      rst      = 1'b1;
      tick();
      chk("rst_mid_pattern",   64'(pattern_out), 64'd0);
      chk("rst_mid_bit_count", 64'(bit_count),   64'd0);
      chk("rst_mid_flags",     64'({pattern_valid, busy, mismatch, done, cfg_err}), 64'd0);
      rst = 1'b0;
      tick();
      done_seen = 0;
      begin_frame(5);
      send_bits(5, 32'h16, 301, -1, -1, 1'b0, 1'b1);
      check_frame1("after_rst");

      for (int f = 0; f < 40; f++) begin
         int w;
         w = $urandom_range(1, 31);
         if ($urandom_range(0, 4) == 0) begin
            pattern_w = 5'd0;
            start     = 1'b1;
            tick();
            start = 1'b0;
         end
         begin_frame(w);
         send_bits(w, $urandom, $urandom_range(1, 320), -1, -1, 1'b1, 1'b1);
      end

      tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
